btb_update_queue: RTL and testbench
===================================

Name: btb_update_queue

Overview:
- Write-side feeder for the branch target buffer.
- Accepts resolved-branch updates from the execute stage and buffers them in a small FIFO.
- Coalesces repeated updates to the same PC into one slot.
- Drains one update per cycle into the BTB load port when the fetch side permits.
- Provides a forwarding lookup so fetch sees pending updates before they are written.

Parameters:
- DEPTH, 4: number of queue slots; power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all queued updates.
- enq_valid  input  1  execute presents a resolved branch update.
- enq_ready  output  1  queue can accept this cycle.
- enq_pc  input  32  PC of the resolved branch (rv32i_word).
- enq_entry  input  34  new BTB payload (btb_entry).
- drain_stall  input  1  fetch forbids a BTB write this cycle (e.g. BTB read hit updating LRU).
- btb_load  output  1  drives BTB load.
- btb_write_address  output  32  drives BTB write_address.
- btb_in  output  34  drives BTB in.
- fwd_address  input  32  current fetch PC.
- fwd_hit  output  1  a queued update matches fwd_address.
- fwd_entry  output  34  payload of the matching update.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer with head/tail pointers and a per-slot valid bit. count is registered. full = (count==DEPTH); empty = (count==0).
- Reset (rst low, asynchronous): head=tail=0, count=0, all slot valids cleared. Outputs: enq_ready=1, btb_load=0, fwd_hit=0, btb_write_address=0, btb_in=0, fwd_entry=0.
- enq_ready = !full, combinational from registered state. It does not depend on same-cycle drain.
- Enqueue fires when enq_valid && enq_ready.
- Coalesce: if a valid slot holds pc == enq_pc, overwrite that slot's entry. No pointer or count change.
  - Exception: if the matching slot is the head and a drain fires this cycle, allocate a new slot at tail instead.
  - The head is then written with the old payload and the new payload follows one cycle later.
- Allocate: with no coalesce, write the update at tail and advance tail modulo DEPTH.
- Drain is combinational: btb_load = !empty && !drain_stall && !flush. btb_write_address = head.pc, btb_in = head.entry. When btb_load=0, both data outputs are 0.
- Drain fires when btb_load=1: clear the head valid bit and advance head modulo DEPTH. The BTB captures the write at the same clock edge.
- Count update: count_next = count + alloc - drain. A simultaneous allocate and drain leaves count unchanged.
- Full: no enqueue, even if a drain fires the same cycle, because enq_ready was already 0. The drain proceeds.
- Empty: btb_load=0 whatever drain_stall is. An enqueue into an empty queue appears on btb_load the next cycle; there is no same-cycle bypass.
- Flush: takes priority over everything. Next state equals the reset state. A same-cycle enqueue is dropped and btb_load is forced 0.
- Forwarding (combinational): compare fwd_address against all valid slots. Because of coalescing, at most one slot matches. fwd_entry is that slot's entry, else 0. The head still matches in a cycle where it is being drained.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble.
- Per-PC ordering is preserved; coalescing guarantees at most one live slot per PC except in the head-drain case above.

Test Plan:
- Reset, then enqueue pc=0x100 (entry A) with drain_stall=1 -> count=1, btb_load=0, fwd_address=0x100 gives fwd_hit=1 and fwd_entry=A. Release stall -> btb_load=1 with address 0x100 and btb_in=A for one cycle, then count=0.
- Hold drain_stall=1 and enqueue 0x100, 0x104, 0x108, 0x10C -> count=4, enq_ready=0. A fifth enqueue is ignored. Release stall -> four writes in FIFO order across the pointer wrap.
- Stall and enqueue 0x200/A, then 0x204/B, then 0x200/C -> count=2. Fetch at 0x200 gives fwd_entry=C. Drain order: 0x200/C, then 0x204/B.
- Queue holds only 0x300/A; enqueue 0x300/B in the same cycle the drain fires -> BTB write 0x300/A this cycle, count stays 1, write 0x300/B next cycle.
- Queue full with drain_stall=0; assert flush together with enq_valid -> btb_load=0 that cycle, next cycle count=0 and enq_ready=1, nothing written.
- Queue at count=3; drive rst low asynchronously mid-cycle -> count=0 and btb_load=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/btb_update_queue_if.sv
// Bundle between the branch-update queue and its execute/fetch/BTB neighbours.
// The master drives requests and fetch controls; the slave is the queue itself.
interface btb_update_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned ENT_W = 34;

    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [PC_W-1:0]  enq_pc;
    logic [ENT_W-1:0] enq_entry;
    logic             drain_stall;
    logic             btb_load;
    logic [PC_W-1:0]  btb_write_address;
    logic [ENT_W-1:0] btb_in;
    logic [PC_W-1:0]  fwd_address;
    logic             fwd_hit;
    logic [ENT_W-1:0] fwd_entry;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, enq_valid, enq_pc, enq_entry, drain_stall, fwd_address,
        input  enq_ready, btb_load, btb_write_address, btb_in, fwd_hit, fwd_entry, count
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_entry, drain_stall, fwd_address,
        output enq_ready, btb_load, btb_write_address, btb_in, fwd_hit, fwd_entry, count
    );
endinterface

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of resolved-branch updates feeding the BTB write port,
// with a forwarding lookup so fetch observes updates before they land.
module btb_update_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    btb_update_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned ENT_W = 34;

    logic [PC_W-1:0]  pc_q    [DEPTH];
    logic [PC_W-1:0]  pc_d    [DEPTH];
    logic [ENT_W-1:0] entry_q [DEPTH];
    logic [ENT_W-1:0] entry_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full, empty, drain, enq_fire, coalesce, alloc;
    logic             match_any, fwd_hit;
    logic [PTR_W-1:0] match_idx;
    logic [ENT_W-1:0] fwd_entry;

    // Occupancy, drain/enqueue qualification, CAM lookups for coalesce and forward
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        drain     = !empty && !bus.drain_stall && !bus.flush;
        enq_fire  = bus.enq_valid && !full && !bus.flush;
        match_any = 1'b0;
        match_idx = '0;
        fwd_hit   = 1'b0;
        fwd_entry = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_q[i] && (pc_q[i] == bus.enq_pc)) begin
                match_any = 1'b1;
                match_idx = PTR_W'(i);
            end
            if (vld_q[i] && (pc_q[i] == bus.fwd_address)) begin
                fwd_hit   = 1'b1;
                fwd_entry = fwd_entry | entry_q[i];
            end
        end
        // A head leaving this cycle already carries its old payload to the BTB
        coalesce = enq_fire && match_any && !(drain && (match_idx == head_q));
        alloc    = enq_fire && !coalesce;
    end

    assign bus.enq_ready         = !full;
    assign bus.btb_load          = drain;
    assign bus.btb_write_address = drain ? pc_q[head_q]    : '0;
    assign bus.btb_in            = drain ? entry_q[head_q] : '0;
    assign bus.fwd_hit           = fwd_hit;
    assign bus.fwd_entry         = fwd_entry;
    assign bus.count             = count_q;

    // Next-state for slots and pointers
    always_comb begin
        pc_d    = pc_q;
        entry_d = entry_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            vld_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (drain) begin
                vld_d[head_q] = 1'b0;
                head_d        = PTR_W'(head_q + 1'b1);
            end
            if (coalesce) begin
                entry_d[match_idx] = bus.enq_entry;
            end
            if (alloc) begin
                pc_d[tail_q]    = bus.enq_pc;
                entry_d[tail_q] = bus.enq_entry;
                vld_d[tail_q]   = 1'b1;
                tail_d          = PTR_W'(tail_q + 1'b1);
            end
            count_d = count_q + CNT_W'(alloc) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                entry_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            entry_q <= entry_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: enqueue, coalesce, drain order,
// wrap, head-drain collision, flush and asynchronous reset.
module tb_btb_update_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [33:0] EA = 34'h2_0000_00AA;
    localparam logic [33:0] EB = 34'h1_1234_00BB;
    localparam logic [33:0] EC = 34'h3_FFFF_00CC;
    localparam logic [33:0] EE = 34'h0_5555_0E00;

    btb_update_queue_if #(.DEPTH(4)) bus ();
    btb_update_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [33:0] e);
        bus.enq_valid = 1'b1;
        bus.enq_pc    = pc;
        bus.enq_entry = e;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    initial begin
        bus.flush       = 1'b0;
        bus.enq_valid   = 1'b0;
        bus.enq_pc      = '0;
        bus.enq_entry   = '0;
        bus.drain_stall = 1'b0;
        bus.fwd_address = '0;
        #3;
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_ready", 64'(bus.enq_ready), 1);
        chk("rst_load", 64'(bus.btb_load), 0);
        chk("rst_fwd", 64'(bus.fwd_hit), 0);
        chk("rst_addr", 64'(bus.btb_write_address), 0);
        chk("rst_in", 64'(bus.btb_in), 0);
        chk("rst_fent", 64'(bus.fwd_entry), 0);
        #9 rst = 1'b1;
        tick();

        // Single update, held, then drained
        bus.drain_stall = 1'b1;
        enq(32'h100, EA);
        #1;
        chk("t1_count", 64'(bus.count), 1);
        chk("t1_load_stall", 64'(bus.btb_load), 0);
        bus.fwd_address = 32'h100;
        #1;
        chk("t1_fwd_hit", 64'(bus.fwd_hit), 1);
        chk("t1_fwd_ent", 64'(bus.fwd_entry), 64'(EA));
        bus.drain_stall = 1'b0;
        #1;
        chk("t1_load", 64'(bus.btb_load), 1);
        chk("t1_addr", 64'(bus.btb_write_address), 64'h100);
        chk("t1_in", 64'(bus.btb_in), 64'(EA));
        chk("t1_fwd_draining", 64'(bus.fwd_hit), 1);
        tick();
        chk("t1_count_after", 64'(bus.count), 0);
        chk("t1_load_after", 64'(bus.btb_load), 0);
        chk("t1_fwd_after", 64'(bus.fwd_hit), 0);

        // Fill to full, drop fifth, drain in order across the wrap
        bus.drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4 * i), EE + 34'(i));
        chk("t2_count_full", 64'(bus.count), 4);
        chk("t2_ready", 64'(bus.enq_ready), 0);
        enq(32'h110, EC);
        chk("t2_count_drop", 64'(bus.count), 4);
        bus.fwd_address = 32'h110;
        #1;
        chk("t2_fwd_dropped", 64'(bus.fwd_hit), 0);
        bus.drain_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_load", 64'(bus.btb_load), 1);
            chk("t2_addr", 64'(bus.btb_write_address), 64'(32'h100 + 32'(4 * i)));
            chk("t2_in", 64'(bus.btb_in), 64'(EE + 34'(i)));
            tick();
        end
        chk("t2_count_empty", 64'(bus.count), 0);
        chk("t2_load_empty", 64'(bus.btb_load), 0);

        // Coalesce 0x200 while stalled
        bus.drain_stall = 1'b1;
        enq(32'h200, EA);
        enq(32'h204, EB);
        enq(32'h200, EC);
        chk("t3_count", 64'(bus.count), 2);
        bus.fwd_address = 32'h200;
        #1;
        chk("t3_fwd_hit", 64'(bus.fwd_hit), 1);
        chk("t3_fwd_ent", 64'(bus.fwd_entry), 64'(EC));
        bus.drain_stall = 1'b0;
        #1;
        chk("t3_addr0", 64'(bus.btb_write_address), 64'h200);
        chk("t3_in0", 64'(bus.btb_in), 64'(EC));
        tick();
        chk("t3_addr1", 64'(bus.btb_write_address), 64'h204);
        chk("t3_in1", 64'(bus.btb_in), 64'(EB));
        tick();
        chk("t3_count_end", 64'(bus.count), 0);

        // Same-PC enqueue while that PC is the draining head
        bus.drain_stall = 1'b1;
        enq(32'h300, EA);
        bus.drain_stall = 1'b0;
        bus.enq_valid   = 1'b1;
        bus.enq_pc      = 32'h300;
        bus.enq_entry   = EB;
        #1;
        chk("t4_load", 64'(bus.btb_load), 1);
        chk("t4_in_old", 64'(bus.btb_in), 64'(EA));
        tick();
        bus.enq_valid = 1'b0;
        #1;
        chk("t4_count", 64'(bus.count), 1);
        chk("t4_addr_new", 64'(bus.btb_write_address), 64'h300);
        chk("t4_in_new", 64'(bus.btb_in), 64'(EB));
        tick();
        chk("t4_count_end", 64'(bus.count), 0);

        // Flush beats a full queue and a same-cycle enqueue
        bus.drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) enq(32'h400 + 32'(4 * i), EE);
        bus.drain_stall = 1'b0;
        bus.flush       = 1'b1;
        bus.enq_valid   = 1'b1;
        bus.enq_pc      = 32'h500;
        bus.enq_entry   = EC;
        #1;
        chk("t5_load_flush", 64'(bus.btb_load), 0);
        chk("t5_in_flush", 64'(bus.btb_in), 0);
        tick();
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        bus.fwd_address = 32'h500;
        #1;
        chk("t5_count", 64'(bus.count), 0);
        chk("t5_ready", 64'(bus.enq_ready), 1);
        chk("t5_load", 64'(bus.btb_load), 0);
        chk("t5_fwd_dropped", 64'(bus.fwd_hit), 0);

        // Asynchronous reset mid-cycle
        bus.drain_stall = 1'b1;
        for (int i = 0; i < 3; i++) enq(32'h600 + 32'(4 * i), EB);
        chk("t6_count3", 64'(bus.count), 3);
        bus.drain_stall = 1'b0;
        #1;
        chk("t6_load_pre", 64'(bus.btb_load), 1);
        rst = 1'b0;
        #1;
        chk("t6_count_rst", 64'(bus.count), 0);
        chk("t6_load_rst", 64'(bus.btb_load), 0);
        chk("t6_ready_rst", 64'(bus.enq_ready), 1);
        #1 rst = 1'b1;
        tick();
        chk("t6_count_post", 64'(bus.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
